// File: rtl/program_encoder_if.sv
// Instruction request / memory write bundle between a program source and the encoder.
interface program_encoder_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [10:0] count;
  logic        done;
  logic        err;

  modport slave (
    input  start, in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data, count, done, err
  );

  modport master (
    output start, in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data, count, done, err
  );
endinterface

// File: rtl/program_encoder.sv
// Encodes MIPS-subset instruction requests and writes them to sequential words of
// instruction memory; one request per two cycles, strobe one cycle after acceptance.
module program_encoder #(
  parameter int DEPTH = 256
) (
  input  logic               clk,
  input  logic               reset,
  program_encoder_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERROR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [AW-1:0] r_addr;
  logic [10:0] r_count;
  logic [31:0] r_word;
  logic        r_is_sys;
  logic        r_done;
  logic        r_err;

  logic [31:0] w_word;
  logic        w_legal;
  logic        w_xfer;
  logic        w_last;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (bus.in_op)
      4'd0:  w_word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'd32};
      4'd1:  w_word = {6'd0, bus.in_rs, 15'd0, 6'd8};
      4'd2:  w_word = {26'd0, 6'd12};
      4'd3:  w_word = {6'd3, bus.in_target};
      4'd4:  w_word = {6'd4,  bus.in_rs, bus.in_rt, bus.in_imm};
      4'd5:  w_word = {6'd5,  bus.in_rs, bus.in_rt, bus.in_imm};
      4'd6:  w_word = {6'd8,  bus.in_rs, bus.in_rt, bus.in_imm};
      4'd7:  w_word = {6'd9,  bus.in_rs, bus.in_rt, bus.in_imm};
      4'd8:  w_word = {6'd10, bus.in_rs, bus.in_rt, bus.in_imm};
      4'd9:  w_word = {6'd35, bus.in_rs, bus.in_rt, bus.in_imm};
      4'd10: w_word = {6'd43, bus.in_rs, bus.in_rt, bus.in_imm};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_xfer = (r_state == S_LOAD) && bus.in_valid;
  assign w_last = (r_addr == AW'(DEPTH - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (bus.start) w_next = S_LOAD;
      S_LOAD:  if (w_xfer) w_next = w_legal ? S_WRITE : S_ERROR;
      S_WRITE: begin
        if (r_is_sys)    w_next = S_DONE;
        else if (w_last) w_next = S_ERROR;
        else             w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_count  <= '0;
      r_word   <= '0;
      r_is_sys <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            r_addr  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            if (w_legal) begin
              r_word   <= w_word;
              r_is_sys <= (bus.in_op == 4'd2);
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_count <= r_count + 11'd1;
          // The last word holds its address: overflow ends the load rather than wrapping.
          if (!w_last) r_addr <= r_addr + AW'(1);
          if (r_is_sys)    r_done <= 1'b1;
          else if (w_last) r_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == S_LOAD);
  assign bus.mem_wr_en   = (r_state == S_WRITE);
  assign bus.mem_addr    = 32'({r_addr, 2'b00});
  assign bus.mem_wr_data = r_word;
  assign bus.count       = r_count;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
endmodule
